// File: rtl/lif_array_if.sv
// Drive/observe bundle for the lif_array neuron block: per-channel current,
// shared configuration, monitor select, and the registered spike/monitor outputs.
interface lif_array_if #(
   parameter int N_NEURONS = 4,
   parameter int V_WIDTH   = 8,
   parameter int I_WIDTH   = 6,
   parameter int R_WIDTH   = 4,
   parameter int MS_WIDTH  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);
   logic                           en;
   logic [N_NEURONS*I_WIDTH-1:0]   I;
   logic [V_WIDTH-1:0]             thresh;
   logic [2:0]                     leak_shift;
   logic [R_WIDTH-1:0]             refrac;
   logic [MS_WIDTH-1:0]            mon_sel;
   logic [N_NEURONS-1:0]           S;
   logic [V_WIDTH-1:0]             v_mon;
   logic                           spike_any;

   modport master (
      output en, I, thresh, leak_shift, refrac, mon_sel,
      input  S, v_mon, spike_any
   );

   modport slave (
      input  en, I, thresh, leak_shift, refrac, mon_sel,
      output S, v_mon, spike_any
   );
endinterface

// File: rtl/lif_array.sv
// Array of N leaky integrate-and-fire neurons with saturating integration,
// shift-based leak, programmable threshold, refractory hold and a membrane monitor.
module lif_array #(
   parameter int N_NEURONS = 4,
   parameter int V_WIDTH   = 8,
   parameter int I_WIDTH   = 6,
   parameter int R_WIDTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   lif_array_if.slave bus
);

   logic [V_WIDTH-1:0]   r_v      [N_NEURONS];
   logic [R_WIDTH-1:0]   r_rcnt   [N_NEURONS];
   logic [N_NEURONS-1:0] r_s;
   logic [V_WIDTH-1:0]   r_v_mon;
   logic                 r_spike_any;

   logic [V_WIDTH-1:0]   w_cur    [N_NEURONS];
   logic [V_WIDTH-1:0]   w_leaked [N_NEURONS];
   logic [V_WIDTH:0]     w_sum    [N_NEURONS];
   logic [V_WIDTH-1:0]   w_vn     [N_NEURONS];
   logic [V_WIDTH-1:0]   w_v_nxt  [N_NEURONS];
   logic [R_WIDTH-1:0]   w_r_nxt  [N_NEURONS];
   logic [N_NEURONS-1:0] w_s_nxt;
   logic [V_WIDTH-1:0]   w_thresh_eff;

   // A zero threshold would fire on every idle cycle; clamp it to 1.
   assign w_thresh_eff = (bus.thresh == '0) ? V_WIDTH'(1) : bus.thresh;

   for (genvar k = 0; k < N_NEURONS; k++) begin : g_chan
      assign w_cur[k]    = {{(V_WIDTH-I_WIDTH){1'b0}}, bus.I[k*I_WIDTH +: I_WIDTH]};
      assign w_leaked[k] = (bus.leak_shift == 3'd0) ? r_v[k]
                                                    : r_v[k] - (r_v[k] >> bus.leak_shift);
      assign w_sum[k]    = {1'b0, w_leaked[k]} + {1'b0, w_cur[k]};
      assign w_vn[k]     = w_sum[k][V_WIDTH] ? {V_WIDTH{1'b1}} : w_sum[k][V_WIDTH-1:0];
   end

   always_comb begin
      w_s_nxt = '0;
      for (int k = 0; k < N_NEURONS; k++) begin
         w_v_nxt[k] = r_v[k];
         w_r_nxt[k] = r_rcnt[k];
         if (r_rcnt[k] != '0) begin
            w_r_nxt[k] = r_rcnt[k] - R_WIDTH'(1);
            w_v_nxt[k] = '0;
         end else if (w_vn[k] >= w_thresh_eff) begin
            w_s_nxt[k] = 1'b1;
            w_v_nxt[k] = '0;
            w_r_nxt[k] = bus.refrac;
         end else begin
            w_v_nxt[k] = w_vn[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            r_v[k]    <= '0;
            r_rcnt[k] <= '0;
         end
         r_s         <= '0;
         r_v_mon     <= '0;
         r_spike_any <= 1'b0;
      end else if (bus.en) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            r_v[k]    <= w_v_nxt[k];
            r_rcnt[k] <= w_r_nxt[k];
         end
         r_s         <= w_s_nxt;
         r_v_mon     <= w_v_nxt[bus.mon_sel];
         r_spike_any <= |w_s_nxt;
      end else begin
         // Spike flags are pulses; never let them linger across a paused cycle.
         r_s         <= '0;
         r_spike_any <= 1'b0;
      end
   end

   assign bus.S         = r_s;
   assign bus.v_mon     = r_v_mon;
   assign bus.spike_any = r_spike_any;

endmodule

// File: doc/lif_array.md
Name: lif_array

Overview:
- Parametrised array of N leaky integrate-and-fire neurons. It is the next generation of the single-channel lif_neuron.
- Adds multi-bit input current per channel, a programmable threshold, a programmable shift-based leak, a refractory period, saturating arithmetic, and a membrane monitor port.
- Sits between the input encoder / synapse stage and the spike router. All N channels update in parallel on each enabled clock.

Parameters:
- N_NEURONS, 4, number of neuron channels.
- V_WIDTH, 8, membrane potential width (unsigned).
- I_WIDTH, 6, per-channel input current width (unsigned), I_WIDTH <= V_WIDTH.
- R_WIDTH, 4, refractory counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  update strobe; when low, all state holds.
- I  in  N_NEURONS*I_WIDTH  per-channel current; channel k = I[k*I_WIDTH +: I_WIDTH].
- thresh  in  V_WIDTH  firing threshold, shared; value 0 treated as 1.
- leak_shift  in  3  leak = V >> leak_shift; 0 disables leak.
- refrac  in  R_WIDTH  refractory cycles after a spike; 0 = none.
- mon_sel  in  $clog2(N_NEURONS)  channel selected for monitoring.
- S  out  N_NEURONS  registered spike flags, one per channel.
- v_mon  out  V_WIDTH  registered membrane value of channel mon_sel.
- spike_any  out  1  registered OR of the S being produced.

Behaviour:
- Reset (async, rst=1): all V=0, all refractory counters=0, S=0, v_mon=0, spike_any=0. Reset is effective immediately, including mid-accumulation or mid-refractory. The first update happens on the first enabled edge after rst deasserts.
- en=0: V, counters and v_mon hold. S and spike_any are forced to 0 on that edge, so a spike pulse is never stretched.
- Per-channel update on each clock edge with en=1. Evaluate in this order:
  - If rcnt != 0: rcnt <= rcnt-1; V <= 0; S <= 0. Input is ignored.
  - Else compute leaked = (leak_shift==0) ? V : V - (V >> leak_shift), then sum = leaked + I_k in V_WIDTH+1 bits.
  - Saturate: vn = (sum > 2^V_WIDTH-1) ? 2^V_WIDTH-1 : sum.
  - If vn >= thresh_eff: S <= 1; V <= 0; rcnt <= refrac.
  - Else: S <= 0; V <= vn.
- Latency: a spike appears on S on the same edge at which the crossing value is computed, i.e. one cycle after the input is sampled. S is a single-cycle pulse.
- v_mon is registered: it shows V of the mon_sel channel after the update (0 on a spike cycle), one cycle after mon_sel is sampled.
- spike_any is registered alongside S.
- Refractory: after a spike, exactly `refrac` enabled cycles hold V=0 and ignore I. A spike can recur no earlier than refrac+1 enabled cycles after the previous one.
- Config inputs (thresh, leak_shift, refrac) are sampled every enabled edge. Changing them mid-run takes effect on the next update without disturbing V.
  - A refrac change does not alter a counter already running.
- Channels are fully independent. Simultaneous spikes on any subset of channels are all reported in the same cycle.

Test Plan (N=4, V_WIDTH=8, I_WIDTH=6, R_WIDTH=4):
1. Integration to spike: rst, then thresh=100, leak_shift=3, refrac=2, I0=20, en=1 -> V0 = 20, 38, 54, 68, 80, 90, 99, then S[0]=1 on the 8th enabled edge (vn=107). V0=0 and S[0]=0 for the next 2 edges; V0=20 on the 3rd.
2. Leak only: bring V0 to 99 (thresh=100, leak_shift=3), then I0=0 -> v_mon (mon_sel=0) = 87, 77, 68, 60. No spike. With leak_shift=0, V0 holds.
3. Saturation: thresh=255, leak_shift=0, I0=63 constant -> V0 = 63, 126, 189, 252, then sum 315 saturates to 255 >= 255, giving S[0]=1 on the 5th edge. No wrap to a small value.
4. Parallel/simultaneous: thresh=40, leak_shift=0, refrac=0, I={40,20,10,0} -> S=4'b0001 on edge 1, S=4'b0011 on edge 2, S=4'b0001 on edge 3, S=4'b0111 on edge 4. spike_any=1 on each of those edges. S[3] never fires.
5. Enable gating: mid-accumulation (V0=54 in scenario 1) drop en for 5 cycles -> V0 holds 54 and S=0. Resume -> sequence continues at 68 and the spike arrives 5 cycles later than in scenario 1.
6. Reset mid-operation: assert rst asynchronously (between edges) while V0=90 and while a refractory count is active -> S, V, v_mon and counters go to 0 immediately. After release, accumulation restarts from 0 with no residual refractory hold.
